// File: rtl/sam_pkg.sv
// -----------------------------------------------------------------------------
// sam_pkg
// Shared definitions for the mem_responder slice: bus widths, the handshake
// FSM state type and the default geometry/latency of the responder.
// -----------------------------------------------------------------------------
package sam_pkg;

  localparam int WORD_W = 16;  // data word width
  localparam int ADDR_W = 16;  // byte address width

  localparam int DEPTH_DEFAULT       = 1024;  // words
  localparam int WAIT_CYCLES_DEFAULT = 2;     // extra busy cycles per access

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM: one write or one read per clock, registered
// read data (rdata shows mem[index] as sampled at the previous rising edge).
//
// Ports
//   clk    in   clock
//   we     in   write enable
//   index  in   word index
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module mem_array
  import sam_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; contents survive rst_n and a
  // reset branch here would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Four-phase memory responder. An access is accepted in IDLE, held busy for
// WAIT_CYCLES+1 cycles, completed on the edge where WAIT falls, and parked in
// DONE until the initiator drops REQUEST.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   ADDRESS_BUS  in   byte address, word index = ADDRESS_BUS[15:1]
//   REQUEST      in   access request, held until completion
//   RW           in   1 = read, 0 = write
//   DATA_BUS     in   write data
//   data_bus_t   out  read data, held until the next completed read
//   WAIT         out  responder busy
//   ERR          out  last completed access was rejected
//
// Build option
//   MEM_RESP_ALIGN_CHECK_EN  when defined, odd byte addresses are rejected;
//                            otherwise ADDRESS_BUS[0] is ignored.
// -----------------------------------------------------------------------------
module mem_responder
  import sam_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ADDRESS_BUS,
  input  logic              REQUEST,
  input  logic              RW,
  input  logic [WORD_W-1:0] DATA_BUS,
  output logic [WORD_W-1:0] data_bus_t,
  output logic              WAIT,
  output logic              ERR
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] dout_d;
  logic              wait_d, err_d;

  logic              out_of_range;
  logic              reject;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_index;
  logic [WORD_W-1:0] mem_rdata;

  assign out_of_range = 32'(addr_q[ADDR_W-1:1]) >= DEPTH;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign reject = out_of_range | addr_q[0];
`else
  assign reject = out_of_range;
  logic unused_align_bit;
  assign unused_align_bit = addr_q[0];
`endif

  // The RAM read is registered, so the index follows the live bus while idle
  // and the latched address afterwards; the word is therefore already on
  // mem_rdata by the last busy cycle, even with WAIT_CYCLES = 0.
  assign mem_index = (state_q == IDLE) ? ADDRESS_BUS[IDX_W:1] : addr_q[IDX_W:1];

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    wait_d  = WAIT;
    err_d   = ERR;
    dout_d  = data_bus_t;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (REQUEST) begin
          addr_d  = ADDRESS_BUS;
          rw_d    = RW;
          wdata_d = DATA_BUS;
          wait_d  = 1'b1;
          count_d = 4'(WAIT_CYCLES);
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          wait_d  = 1'b0;
          err_d   = reject;
          state_d = DONE;
          if (rw_q) begin
            dout_d = reject ? '0 : mem_rdata;
          end else begin
            // Gated by rst_n so a reset landing on the completion edge
            // still aborts the write.
            mem_we = ~reject & rst_n;
          end
        end
      end
      DONE: begin
        if (!REQUEST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      WAIT       <= 1'b0;
      ERR        <= 1'b0;
      data_bus_t <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      WAIT       <= wait_d;
      ERR        <= err_d;
      data_bus_t <= dout_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .index (mem_index),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
